// File: rtl/decode_execute_register_pkg.sv
// decode_execute_register_pkg: shared core types for the decode/execute boundary
// XLEN, the decoded control bundle ctrl_t and its all-zero CTRL_NOP.
// Optional feature macro: RV_VECTOR_EN (vector control fields become live).
package decode_execute_register_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic       write_scalar_reg;
    logic [1:0] result_source;
    logic [2:0] width_type;
    logic       mem_write;
    logic [3:0] alu_op;
    logic [2:0] cond_code;
    logic       alu_source;
    logic       jump;
    logic       i_jump;
    logic       branch;
    logic       pc_to_alu;
    logic       memory_transaction;
    logic       immediate_i_exception;
    logic       write_vector_reg;
    logic       select_operand_0_vector;
    logic       select_operand_1_vector;
    logic       rerouting_select;
    logic [2:0] rerouting_code;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  // Vector fields are tied to zero unless the vector extension is built in,
  // so their flops fold away to constants.
  function automatic ctrl_t scalar_view(ctrl_t c);
    ctrl_t r;
    r = c;
`ifndef RV_VECTOR_EN
    r.write_vector_reg        = 1'b0;
    r.select_operand_0_vector = 1'b0;
    r.select_operand_1_vector = 1'b0;
    r.rerouting_select        = 1'b0;
    r.rerouting_code          = 3'd0;
`endif
    return r;
  endfunction
endpackage

// File: rtl/decode_execute_register_load_use_detector.sv
// load_use_detector: combinational load-use hazard between EX load and ID consumer
// Inputs: ID valid/sources/operand-usage bits, EX valid/rd/load-kind bits, redirect.
// Output: stall_o. Macro RV_VECTOR_EN adds the vector-load hazard term and its ports.
module load_use_detector (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_pc_to_alu_i,
  input  logic       id_alu_source_i,
  input  logic       id_mem_write_i,
  input  logic       id_branch_i,
`ifdef RV_VECTOR_EN
  input  logic       id_sel0_vec_i,
  input  logic       id_sel1_vec_i,
  input  logic       ex_write_vector_i,
`endif
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_tx_i,
  input  logic       ex_mem_write_i,
  input  logic       ex_write_scalar_i,
  input  logic       redirect_i,
  output logic       stall_o
);
  logic gate, uses_rs2, scalar_hit, vector_hit;
  assign gate       = id_valid_i & ex_valid_i & ~redirect_i;
  assign uses_rs2   = ~id_alu_source_i | id_mem_write_i | id_branch_i;
  assign scalar_hit = ex_mem_tx_i & ~ex_mem_write_i & ex_write_scalar_i & (ex_rd_i != 5'd0) &
                      (((ex_rd_i == id_rs1_i) & ~id_pc_to_alu_i) | ((ex_rd_i == id_rs2_i) & uses_rs2));
`ifdef RV_VECTOR_EN
  assign vector_hit = ex_mem_tx_i & ex_write_vector_i & ~ex_mem_write_i &
                      (((ex_rd_i == id_rs1_i) & id_sel0_vec_i) | ((ex_rd_i == id_rs2_i) & id_sel1_vec_i));
`else
  assign vector_hit = 1'b0;
`endif
  assign stall_o = gate & (scalar_hit | vector_hit);
endmodule

// File: rtl/decode_execute_register.sv
// decode_execute_register: ID/EX pipeline register with load-use bubble insertion
// In:  clk, rst (async high), id_valid/id_ctrl/id_pc/id_imm/id_rs1/id_rs2/id_rd, ex_stall, redirect.
// Out: ex_valid/ex_ctrl/ex_pc/ex_imm/ex_rs1/ex_rs2/ex_rd, load_use_stall (comb), bubble_count.
// Edge priority: redirect > ex_stall > load_use_stall > capture. Macro RV_VECTOR_EN enables vector fields.
module decode_execute_register
  import decode_execute_register_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  ctrl_t           id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            ex_stall,
  input  logic            redirect,
  output logic            ex_valid,
  output ctrl_t           ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            load_use_stall,
  output logic [15:0]     bubble_count
);
  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            lus, kill, take, bubble;
  load_use_detector u_lud (
    .id_valid_i        (id_valid),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_pc_to_alu_i    (id_ctrl.pc_to_alu),
    .id_alu_source_i   (id_ctrl.alu_source),
    .id_mem_write_i    (id_ctrl.mem_write),
    .id_branch_i       (id_ctrl.branch),
`ifdef RV_VECTOR_EN
    .id_sel0_vec_i     (id_ctrl.select_operand_0_vector),
    .id_sel1_vec_i     (id_ctrl.select_operand_1_vector),
    .ex_write_vector_i (ctrl_q.write_vector_reg),
`endif
    .ex_valid_i        (valid_q),
    .ex_rd_i           (rd_q),
    .ex_mem_tx_i       (ctrl_q.memory_transaction),
    .ex_mem_write_i    (ctrl_q.mem_write),
    .ex_write_scalar_i (ctrl_q.write_scalar_reg),
    .redirect_i        (redirect),
    .stall_o           (lus)
  );
  // lus is already masked by redirect inside the detector.
  assign bubble = ~ex_stall & lus;
  assign kill   = redirect | bubble;
  assign take   = ~redirect & ~ex_stall & ~lus;
  // Empty slots carry a zero control bundle so nothing downstream can act on stale bits.
  always_comb begin
    valid_d = kill ? 1'b0 : take ? id_valid : valid_q;
    ctrl_d  = kill ? CTRL_NOP : take ? (id_valid ? scalar_view(id_ctrl) : CTRL_NOP) : ctrl_q;
    pc_d    = take ? id_pc  : pc_q;
    imm_d   = take ? id_imm : imm_q;
    rs1_d   = take ? id_rs1 : rs1_q;
    rs2_d   = take ? id_rs2 : rs2_q;
    rd_d    = take ? id_rd  : rd_q;
    cnt_d   = (bubble & ~&cnt_q) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ex_valid       = valid_q;
  assign ex_ctrl        = ctrl_q;
  assign ex_pc          = pc_q;
  assign ex_imm         = imm_q;
  assign ex_rs1         = rs1_q;
  assign ex_rs2         = rs2_q;
  assign ex_rd          = rd_q;
  assign load_use_stall = lus;
  assign bubble_count   = cnt_q;
endmodule

// File: tb/tb_decode_execute_register.sv
// tb_decode_execute_register: table vectors, corner sequences and random model check
module tb_decode_execute_register;
  import decode_execute_register_pkg::*;
  logic        clk = 1'b0, rst = 1'b0;
  logic        id_valid, ex_stall, redirect;
  ctrl_t       id_ctrl;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_valid, load_use_stall;
  ctrl_t       ex_ctrl;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] bubble_count;
  int passed = 0, total = 0;

  decode_execute_register dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_stall(ex_stall), .redirect(redirect),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic ctrl_t mk_alu(input logic [3:0] op, input logic imm);
    ctrl_t c = CTRL_NOP;
    c.write_scalar_reg = 1'b1; c.alu_op = op; c.alu_source = imm;
    return c;
  endfunction
  function automatic ctrl_t mk_load();
    ctrl_t c = CTRL_NOP;
    c.write_scalar_reg = 1'b1; c.memory_transaction = 1'b1; c.alu_source = 1'b1; c.result_source = 2'd1;
    return c;
  endfunction
  function automatic ctrl_t mk_store();
    ctrl_t c = CTRL_NOP;
    c.memory_transaction = 1'b1; c.mem_write = 1'b1; c.alu_source = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t mk_jump();
    ctrl_t c = CTRL_NOP;
    c.write_scalar_reg = 1'b1; c.pc_to_alu = 1'b1; c.alu_source = 1'b1; c.jump = 1'b1; c.alu_op = 4'd3;
    return c;
  endfunction

  task automatic drive(input logic v, input ctrl_t c, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic st, input logic rdr);
    id_valid = v; id_ctrl = c; id_pc = pc; id_imm = ~pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    ex_stall = st; redirect = rdr;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ex_valid"}, ex_valid, 0);
    chk({tag, " ex_ctrl"}, ex_ctrl, 0);
    chk({tag, " ex_pc"}, ex_pc, 0);
    chk({tag, " ex_imm"}, ex_imm, 0);
    chk({tag, " ex_regs"}, {ex_rs1, ex_rs2, ex_rd}, 0);
    chk({tag, " bubble_count"}, bubble_count, 0);
  endtask

  task automatic do_reset();
    drive(0, CTRL_NOP, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2 chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic v; ctrl_t c; logic [31:0] pc; logic [4:0] rs1, rs2, rd; logic st, rdr;
    logic e_lus, e_v; logic [31:0] e_pc; logic [3:0] e_alu; logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mkv(input logic v, input ctrl_t c, input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic st, input logic rdr,
                               input logic e_lus, input logic e_v, input logic [31:0] e_pc,
                               input logic [3:0] e_alu, input logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.c = c; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.st = st; r.rdr = rdr;
    r.e_lus = e_lus; r.e_v = e_v; r.e_pc = e_pc; r.e_alu = e_alu; r.e_cnt = e_cnt;
    return r;
  endfunction

  // Behavioural reference: architectural contents of the EX slot.
  logic        m_valid;
  ctrl_t       m_ctrl;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          m_cnt;

  function automatic ctrl_t visible(input ctrl_t c);
    ctrl_t r = c;
`ifndef RV_VECTOR_EN
    {r.write_vector_reg, r.select_operand_0_vector, r.select_operand_1_vector, r.rerouting_select, r.rerouting_code} = '0;
`endif
    return r;
  endfunction

  function automatic logic ref_hazard();
    logic reads1, reads2, hit;
    if (!id_valid || !m_valid || redirect) return 1'b0;
    reads1 = !id_ctrl.pc_to_alu;
    reads2 = !id_ctrl.alu_source || id_ctrl.mem_write || id_ctrl.branch;
    hit = m_ctrl.memory_transaction && !m_ctrl.mem_write && m_ctrl.write_scalar_reg && m_rd != 0 &&
          ((reads1 && id_rs1 == m_rd) || (reads2 && id_rs2 == m_rd));
`ifdef RV_VECTOR_EN
    if (m_ctrl.memory_transaction && m_ctrl.write_vector_reg && !m_ctrl.mem_write &&
        ((id_ctrl.select_operand_0_vector && id_rs1 == m_rd) || (id_ctrl.select_operand_1_vector && id_rs2 == m_rd)))
      hit = 1'b1;
`endif
    return hit;
  endfunction

  task automatic ref_edge(input logic hz);
    if (redirect) begin
      m_valid = 0; m_ctrl = CTRL_NOP;
    end else if (ex_stall) begin
    end else if (hz) begin
      m_valid = 0; m_ctrl = CTRL_NOP;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_valid = id_valid; m_ctrl = id_valid ? visible(id_ctrl) : CTRL_NOP;
      m_pc = id_pc; m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
    end
  endtask

  initial begin
    logic [15:0] sat_exp [5];
    logic hz;
    sat_exp[0] = 16'hFFFE; sat_exp[1] = 16'hFFFE; sat_exp[2] = 16'hFFFF; sat_exp[3] = 16'hFFFF; sat_exp[4] = 16'hFFFF;
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h100, 1, 2, 3, 0, 0, 0, 1, 32'h100, 3, 0));
    tbl.push_back(mkv(1, mk_load(),   32'h104, 1, 0, 5, 0, 0, 0, 1, 32'h104, 0, 0));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h108, 5, 6, 7, 0, 0, 1, 0, 32'h0,   0, 1));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h108, 5, 6, 7, 0, 0, 0, 1, 32'h108, 3, 1));
    tbl.push_back(mkv(1, mk_load(),   32'h10c, 0, 0, 5, 0, 0, 0, 1, 32'h10c, 0, 1));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h110, 5, 6, 7, 1, 0, 1, 1, 32'h10c, 0, 1));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h110, 5, 6, 7, 1, 0, 1, 1, 32'h10c, 0, 1));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h110, 5, 6, 7, 1, 0, 1, 1, 32'h10c, 0, 1));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h110, 5, 6, 7, 0, 0, 1, 0, 32'h0,   0, 2));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h110, 5, 6, 7, 0, 0, 0, 1, 32'h110, 3, 2));
    tbl.push_back(mkv(1, mk_load(),   32'h114, 1, 0, 9, 0, 0, 0, 1, 32'h114, 0, 2));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h118, 1, 9, 3, 1, 1, 0, 0, 32'h0,   0, 2));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h118, 1, 9, 3, 0, 0, 0, 1, 32'h118, 3, 2));
    tbl.push_back(mkv(1, mk_load(),   32'h11c, 1, 0, 0, 0, 0, 0, 1, 32'h11c, 0, 2));
    tbl.push_back(mkv(1, mk_alu(3,0), 32'h120, 0, 0, 3, 0, 0, 0, 1, 32'h120, 3, 2));
    tbl.push_back(mkv(1, mk_load(),   32'h124, 1, 0, 4, 0, 0, 0, 1, 32'h124, 0, 2));
    tbl.push_back(mkv(1, mk_alu(3,1), 32'h128, 1, 4, 3, 0, 0, 0, 1, 32'h128, 3, 2));
    tbl.push_back(mkv(1, mk_load(),   32'h12c, 1, 0, 4, 0, 0, 0, 1, 32'h12c, 0, 2));
    tbl.push_back(mkv(1, mk_store(),  32'h130, 1, 4, 0, 0, 0, 1, 0, 32'h0,   0, 3));
    tbl.push_back(mkv(1, mk_store(),  32'h130, 1, 4, 0, 0, 0, 0, 1, 32'h130, 0, 3));
    tbl.push_back(mkv(1, mk_load(),   32'h134, 1, 0, 8, 0, 0, 0, 1, 32'h134, 0, 3));
    tbl.push_back(mkv(1, mk_jump(),   32'h138, 8, 0, 1, 0, 0, 0, 1, 32'h138, 3, 3));
    tbl.push_back(mkv(1, mk_load(),   32'h13c, 1, 0, 10, 0, 0, 0, 1, 32'h13c, 0, 3));
    tbl.push_back(mkv(0, mk_alu(3,0), 32'h140, 10, 0, 3, 0, 0, 0, 0, 32'h0,  0, 3));

    drive(0, CTRL_NOP, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #2 chk_zero("power-on reset");
    #9 rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].st, tbl[i].rdr);
      #2 chk($sformatf("vec%0d load_use_stall", i), load_use_stall, tbl[i].e_lus);
      @(posedge clk); #1;
      chk($sformatf("vec%0d ex_valid", i), ex_valid, tbl[i].e_v);
      chk($sformatf("vec%0d alu_op", i), ex_ctrl.alu_op, tbl[i].e_alu);
      chk($sformatf("vec%0d bubble_count", i), bubble_count, tbl[i].e_cnt);
      if (tbl[i].e_v) chk($sformatf("vec%0d ex_pc", i), ex_pc, tbl[i].e_pc);
      if (!tbl[i].e_v) chk($sformatf("vec%0d ex_ctrl zero", i), ex_ctrl, 0);
    end

    // Asynchronous reset while a load-use stall is pending.
    drive(1, mk_load(), 32'h200, 1, 0, 5, 0, 0);
    @(posedge clk); #1;
    drive(1, mk_alu(3,0), 32'h204, 5, 6, 7, 0, 0);
    #1 chk("pre-reset load_use_stall", load_use_stall, 1);
    rst = 1'b1;
    #1 chk_zero("async reset");
    chk("async reset load_use_stall", load_use_stall, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset capture valid", ex_valid, 1);
    chk("post-reset capture pc", ex_pc, 32'h204);
    chk("post-reset bubble_count", bubble_count, 0);

    // Saturation: preset the counter just below the top, then keep hitting hazards.
    drive(1, mk_load(), 32'h300, 5, 0, 5, 0, 0);
    @(posedge clk); #1;
    force dut.cnt_q = 16'hFFFD;
    #1 release dut.cnt_q;
    chk("preset bubble_count", bubble_count, 16'hFFFD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d ex_valid", i), ex_valid, logic'(i % 2));
      chk($sformatf("sat%0d bubble_count", i), bubble_count, sat_exp[i]);
    end

`ifdef RV_VECTOR_EN
    begin
      ctrl_t vl, vu;
      do_reset();
      vl = CTRL_NOP; vl.memory_transaction = 1; vl.write_vector_reg = 1;
      vu = CTRL_NOP; vu.select_operand_0_vector = 1; vu.alu_source = 1;
      drive(1, vl, 32'h400, 1, 0, 2, 0, 0);
      @(posedge clk); #1;
      drive(1, vu, 32'h404, 2, 0, 3, 0, 0);
      #1 chk("vec load-use stall", load_use_stall, 1);
      @(posedge clk); #1;
      chk("vec bubble valid", ex_valid, 0);
      chk("vec bubble count", bubble_count, 1);
      @(posedge clk); #1;
      chk("vec capture valid", ex_valid, 1);
      chk("vec count stays", bubble_count, 1);
    end
`endif

    // Randomized run against the reference model.
    do_reset();
    m_valid = 0; m_ctrl = CTRL_NOP; m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      id_valid = $urandom_range(0, 3) != 0;
      id_ctrl  = ctrl_t'($urandom);
      id_pc    = $urandom; id_imm = $urandom;
      id_rs1   = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
      ex_stall = $urandom_range(0, 3) == 0;
      redirect = $urandom_range(0, 7) == 0;
      #2 hz = ref_hazard();
      chk("rnd load_use_stall", load_use_stall, hz);
      ref_edge(hz);
      @(posedge clk); #1;
      chk("rnd ex_valid", ex_valid, m_valid);
      chk("rnd ex_ctrl", ex_ctrl, m_ctrl);
      chk("rnd bubble_count", bubble_count, 16'(m_cnt));
      if (m_valid) chk("rnd ex_data", {ex_pc, ex_imm}, {m_pc, m_imm});
      if (m_valid) chk("rnd ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m_rs1, m_rs2, m_rd});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
